led_pattern_gen: RTL and testbench
==================================

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 SHALL have parameter LED_W, default 8: number of LED outputs, legal range 1..32.
REQ-002 SHALL have parameter RATE_W, default 24: prescaler/rate width.
REQ-003 SHALL have parameter PWM_W, default 8: breathe duty and PWM resolution.
REQ-004 SHALL have parameter RESET_RATE, default 24'd12_499_999: rate loaded at reset.
REQ-005 SHALL have port clk_clk, input, 1: sole clock, all logic on its rising edge.
REQ-006 SHALL have port reset_reset_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port cfg_valid, input, 1: configuration offer.
REQ-008 SHALL have port cfg_ready, output, 1: configuration can be accepted.
REQ-009 SHALL have port cfg_mode, input, 2: 0 COUNT, 1 SCAN, 2 BREATHE, 3 HOLD.
REQ-010 SHALL have port cfg_rate, input, RATE_W: tick period minus one, in clocks.
REQ-011 SHALL have port tick, output, 1: one-cycle pulse per pattern step.
REQ-012 SHALL have port led, output, LED_W: pattern output, registered.

Function
REQ-013 SHALL run a prescaler: count 0..rate, assert tick in the cycle count==rate, then reload 0; rate 0 -> tick every cycle.
REQ-014 SHALL accept configuration when cfg_valid && cfg_ready, latch mode and rate into a pending register, and deassert cfg_ready next cycle.
REQ-015 SHALL apply pending configuration in the cycle of the next tick: mode/rate updated, prescaler restarts at 0, pattern state cleared, cfg_ready reasserted next cycle.
REQ-016 SHALL ignore cfg_valid while cfg_ready is low; the pending value is not overwritten.
REQ-017 SHALL, on applying a configuration, clear pattern state even if the mode is unchanged: COUNT value 0, SCAN position 0 direction up, BREATHE duty 0 direction up.
REQ-018 COUNT: led = LED_W-bit counter, +1 per tick, wraps all-ones -> 0.
REQ-019 SCAN: led one-hot at pos; per tick pos moves one step in dir; at pos LED_W-1 going up the next pos is LED_W-2 with dir down; at pos 0 going down the next pos is 1 with dir up; LED_W=1 holds pos 0.
REQ-020 BREATHE: duty ramps +1 per tick to 2^PWM_W-1, then -1 per tick to 0, then up again; the endpoints are held for exactly one tick each.
REQ-021 BREATHE: free-running PWM_W-bit PWM counter increments every clock; all LED bits = (pwm_cnt < duty), registered; duty 0 -> always off.
REQ-022 HOLD: led frozen at its value in the cycle the configuration is applied; tick still pulses.
REQ-023 SHALL update led one clock after the tick that advances the pattern (latency 1).
REQ-024 SHALL treat a change of rate as taking effect only at the apply-tick, never mid-period.

Reset
REQ-025 SHALL, while reset_reset_n is low, force: led 0, tick 0, cfg_ready 1, mode COUNT, rate RESET_RATE, prescaler 0, pending cleared, pattern state cleared.
REQ-026 SHALL abandon a pending configuration if reset is asserted before it is applied.
REQ-027 SHALL resume on the first rising edge after deassertion with the first tick at clock RESET_RATE+1.

Configuration
REQ-028 SHALL compile BREATHE logic and the PWM sub-module only when macro LED_PATTERN_BREATHE_EN is defined.
REQ-029 SHALL, without LED_PATTERN_BREATHE_EN, treat cfg_mode 2 as HOLD; all other modes are unchanged.

Structure
REQ-030 SHALL take the mode encoding (enum), the mode-count constant, and the default parameter values from shared package led_pattern_pkg.
REQ-031 SHALL implement the PWM counter/compare as sub-module led_pwm (params PWM_W; ports clk_clk, reset_reset_n, duty, pwm_out).

Verification
REQ-032 Reset, LED_W=8, rate 3, COUNT -> tick every 4 clocks; led 0,1,2,... one clock after each tick; 0xFF -> 0x00 wrap.
REQ-033 SCAN, LED_W=4, rate 0 -> led 0001,0010,0100,1000,0100,0010,0001,0010 on successive cycles.
REQ-034 Offer config in mid-period with rate 9 -> cfg_ready low until the next tick; second offer during pending is ignored; new mode applied with led reset per REQ-017.
REQ-035 BREATHE, PWM_W=4, duty forced 5 -> led high 5 of every 16 clocks; duty 0 -> never high; ramp reaches 15 and returns to 0.
REQ-036 Assert reset_reset_n low asynchronously mid-SCAN with pending config -> outputs cleared immediately, pending dropped, COUNT at RESET_RATE after release.
REQ-037 Build without LED_PATTERN_BREATHE_EN, request mode 2 -> led freezes at its current value, tick continues.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// -----------------------------------------------------------------------------
// led_pattern_pkg
// Shared definitions for the LED pattern generator: the pattern mode encoding,
// the configuration handshake state encoding, default parameter values and the
// helper that maps a raw cfg_mode request onto a supported mode.
//
// Build option: LED_PATTERN_BREATHE_EN -- when undefined, a BREATHE request is
// served as HOLD.
// -----------------------------------------------------------------------------
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT   = 2'd0,
        MODE_SCAN    = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_HOLD    = 2'd3
    } mode_e;

    localparam int MODE_NUM = 4;

    // Configuration handshake: IDLE accepts an offer, PEND holds it until
    // the next prescaler tick applies it.
    typedef enum logic {
        CFG_IDLE = 1'b0,
        CFG_PEND = 1'b1
    } cfg_state_e;

    localparam int          DEF_LED_W      = 8;
    localparam int          DEF_RATE_W     = 24;
    localparam int          DEF_PWM_W      = 8;
    localparam logic [23:0] DEF_RESET_RATE = 24'd12_499_999;

    // Without the breathe engine, mode 2 degrades to HOLD.
    function automatic mode_e map_mode(input logic [1:0] raw);
`ifdef LED_PATTERN_BREATHE_EN
        return mode_e'(raw);
`else
        return (raw == 2'd2) ? MODE_HOLD : mode_e'(raw);
`endif
    endfunction

endpackage

// File: rtl/led_pattern_gen_pwm.sv
// -----------------------------------------------------------------------------
// led_pwm
// Free-running PWM_W-bit counter and duty compare used by BREATHE mode.
// Only present when LED_PATTERN_BREATHE_EN is defined.
//
// Ports:
//   clk_clk        in   clock, rising edge
//   reset_reset_n  in   asynchronous active-low reset
//   duty           in   PWM_W  on-time per 2^PWM_W clocks (0 = always off)
//   pwm_out        out  1      pwm_cnt < duty (combinational; the caller
//                              registers it)
// -----------------------------------------------------------------------------
`ifdef LED_PATTERN_BREATHE_EN
module led_pwm
    import led_pattern_pkg::*;
#(
    parameter int PWM_W = DEF_PWM_W
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [PWM_W-1:0] duty,
    output logic             pwm_out
);

    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    assign pwm_out = (pwm_cnt < duty);

endmodule
`endif

// File: rtl/led_pattern_gen.sv
// -----------------------------------------------------------------------------
// led_pattern_gen
// Prescaled LED pattern generator with COUNT, SCAN, BREATHE and HOLD modes.
//
// Ports:
//   clk_clk        in   clock, rising edge
//   reset_reset_n  in   asynchronous active-low reset
//   cfg_valid      in   configuration offer
//   cfg_ready      out  configuration can be accepted
//   cfg_mode       in   2       0 COUNT, 1 SCAN, 2 BREATHE, 3 HOLD
//   cfg_rate       in   RATE_W  tick period minus one, in clocks
//   tick           out  one-cycle pulse per pattern step
//   led            out  LED_W   registered pattern output
//
// Build option: LED_PATTERN_BREATHE_EN enables BREATHE and the led_pwm
// sub-module; without it mode 2 behaves as HOLD.
//
// Handshake: an offer is taken on a rising edge where cfg_valid && cfg_ready.
// cfg_ready then stays low while the offer is pending and cfg_valid is ignored;
// the pending mode/rate are applied on the edge that ends the next tick cycle,
// and cfg_ready rises again in the following cycle.
// -----------------------------------------------------------------------------
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int                LED_W      = DEF_LED_W,
    parameter int                RATE_W     = DEF_RATE_W,
    parameter int                PWM_W      = DEF_PWM_W,
    parameter logic [RATE_W-1:0] RESET_RATE = RATE_W'(DEF_RESET_RATE)
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_mode,
    input  logic [RATE_W-1:0] cfg_rate,
    output logic              tick,
    output logic [LED_W-1:0]  led
);

    localparam int               POS_W    = (LED_W > 1) ? $clog2(LED_W) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(LED_W - 1);

    if (LED_W < 1 || LED_W > 32) begin : g_bad_led_w
        $error("led_pattern_gen: LED_W must be 1..32");
    end
    if (PWM_W < 1) begin : g_bad_pwm_w
        $error("led_pattern_gen: PWM_W must be at least 1");
    end
    if ($bits(mode_e) != $clog2(MODE_NUM)) begin : g_bad_mode_enc
        $error("led_pattern_gen: mode encoding does not match MODE_NUM");
    end

    cfg_state_e        cfg_state, cfg_state_nxt;
    logic              accept;
    logic              apply;
    mode_e             pend_mode;
    logic [RATE_W-1:0] pend_rate;

    mode_e             mode;
    logic [RATE_W-1:0] rate;
    logic [RATE_W-1:0] cnt;

    logic [LED_W-1:0]  count_val, count_nxt;
    logic [POS_W-1:0]  scan_pos, scan_pos_nxt;
    logic              scan_up, scan_up_nxt;
    logic [LED_W-1:0]  led_nxt;

    // ---------------- configuration handshake FSM ----------------
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cfg_state <= CFG_IDLE;
        end else begin
            cfg_state <= cfg_state_nxt;
        end
    end

    always_comb begin
        cfg_state_nxt = cfg_state;
        case (cfg_state)
            CFG_IDLE: if (accept) cfg_state_nxt = CFG_PEND;
            CFG_PEND: if (tick)   cfg_state_nxt = CFG_IDLE;
            default:              cfg_state_nxt = CFG_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (cfg_state == CFG_IDLE);
        apply     = (cfg_state == CFG_PEND) && tick;
    end

    assign accept = cfg_valid && cfg_ready;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pend_mode <= MODE_COUNT;
            pend_rate <= '0;
        end else if (accept) begin
            pend_mode <= map_mode(cfg_mode);
            pend_rate <= cfg_rate;
        end
    end

    // ---------------- prescaler and active configuration ----------------
    assign tick = (cnt == rate);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mode <= MODE_COUNT;
            rate <= RESET_RATE;
            cnt  <= '0;
        end else if (apply) begin
            mode <= pend_mode;
            rate <= pend_rate;
            cnt  <= '0;
        end else if (tick) begin
            cnt  <= '0;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

    // ---------------- pattern step logic ----------------
    always_comb begin
        count_nxt    = count_val + 1'b1;
        scan_pos_nxt = scan_pos;
        scan_up_nxt  = scan_up;
        // A single LED has nowhere to move: position stays 0.
        if (LED_W > 1) begin
            if (scan_up) begin
                if (scan_pos == POS_LAST) begin
                    scan_pos_nxt = scan_pos - 1'b1;
                    scan_up_nxt  = 1'b0;
                end else begin
                    scan_pos_nxt = scan_pos + 1'b1;
                end
            end else begin
                if (scan_pos == '0) begin
                    scan_pos_nxt = scan_pos + 1'b1;
                    scan_up_nxt  = 1'b1;
                end else begin
                    scan_pos_nxt = scan_pos - 1'b1;
                end
            end
        end
    end

`ifdef LED_PATTERN_BREATHE_EN
    localparam logic [PWM_W-1:0] DUTY_MAX = {PWM_W{1'b1}};

    logic [PWM_W-1:0] duty, duty_nxt;
    logic             duty_up, duty_up_nxt;
    logic             pwm_out;

    // Endpoints are visited once: the step after 2^PWM_W-1 is already
    // descending, the step after 0 is already ascending.
    always_comb begin
        duty_nxt    = duty;
        duty_up_nxt = duty_up;
        if (duty_up) begin
            if (duty == DUTY_MAX) begin
                duty_nxt    = duty - 1'b1;
                duty_up_nxt = 1'b0;
            end else begin
                duty_nxt    = duty + 1'b1;
            end
        end else begin
            if (duty == '0) begin
                duty_nxt    = duty + 1'b1;
                duty_up_nxt = 1'b1;
            end else begin
                duty_nxt    = duty - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            duty    <= '0;
            duty_up <= 1'b1;
        end else if (apply) begin
            duty    <= '0;
            duty_up <= 1'b1;
        end else if (tick && mode == MODE_BREATHE) begin
            duty    <= duty_nxt;
            duty_up <= duty_up_nxt;
        end
    end

    led_pwm #(
        .PWM_W (PWM_W)
    ) u_pwm (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .duty          (duty),
        .pwm_out       (pwm_out)
    );
`endif

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            count_val <= '0;
            scan_pos  <= '0;
            scan_up   <= 1'b1;
        end else if (apply) begin
            count_val <= '0;
            scan_pos  <= '0;
            scan_up   <= 1'b1;
        end else if (tick) begin
            case (mode)
                MODE_COUNT: count_val <= count_nxt;
                MODE_SCAN: begin
                    scan_pos <= scan_pos_nxt;
                    scan_up  <= scan_up_nxt;
                end
                default: ;
            endcase
        end
    end

    // led is loaded from the post-step pattern, so it changes on the edge
    // that ends the tick cycle. On apply it shows the cleared pattern of the
    // new mode, except HOLD which keeps whatever is currently displayed.
    always_comb begin
        led_nxt = led;
        if (apply) begin
            case (pend_mode)
                MODE_COUNT:   led_nxt = '0;
                MODE_SCAN:    led_nxt = LED_W'(1);
`ifdef LED_PATTERN_BREATHE_EN
                MODE_BREATHE: led_nxt = '0;
`endif
                default:      led_nxt = led;
            endcase
        end else begin
            case (mode)
                MODE_COUNT:   if (tick) led_nxt = count_nxt;
                MODE_SCAN:    if (tick) led_nxt = LED_W'(1) << scan_pos_nxt;
`ifdef LED_PATTERN_BREATHE_EN
                MODE_BREATHE: led_nxt = {LED_W{pwm_out}};
`endif
                default:      led_nxt = led;
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            led <= '0;
        end else begin
            led <= led_nxt;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_gen
// Directed bench for led_pattern_gen. Two instances share clock and inputs:
// u8 (LED_W=8) and u4 (LED_W=4), both RATE_W=8, PWM_W=4, RESET_RATE=3, so
// their tick/cfg_ready timing is identical and only the LED widths differ.
// Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_led_pattern_gen;
    import led_pattern_pkg::*;

    localparam int RATE_W = 8;
    localparam int PWM_W  = 4;

    logic              clk_clk       = 1'b0;
    logic              reset_reset_n = 1'b0;
    logic              cfg_valid     = 1'b0;
    logic [1:0]        cfg_mode      = 2'd0;
    logic [RATE_W-1:0] cfg_rate      = '0;

    logic       cfg_ready8, tick8, cfg_ready4, tick4;
    logic [7:0] led8;
    logic [3:0] led4;

    int checks = 0;
    int errors = 0;

    logic [7:0] scan8_tbl [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                   8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic [3:0] scan4_tbl [6]  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2};

    // ---------------- clock ----------------
    always #5 clk_clk = ~clk_clk;

    led_pattern_gen #(
        .LED_W (8), .RATE_W (RATE_W), .PWM_W (PWM_W), .RESET_RATE (8'd3)
    ) u8 (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready8),
        .cfg_mode      (cfg_mode),
        .cfg_rate      (cfg_rate),
        .tick          (tick8),
        .led           (led8)
    );

    led_pattern_gen #(
        .LED_W (4), .RATE_W (RATE_W), .PWM_W (PWM_W), .RESET_RATE (8'd3)
    ) u4 (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready4),
        .cfg_mode      (cfg_mode),
        .cfg_rate      (cfg_rate),
        .tick          (tick4),
        .led           (led4)
    );

    // ---------------- driver / checker tasks ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic chk_led(input string tag, input logic [7:0] e8, input logic [3:0] e4);
        chk({tag, "_led8"}, 32'(led8), 32'(e8));
        chk({tag, "_led4"}, 32'(led4), 32'(e4));
    endtask

    task automatic chk_hs(input string tag, input logic e_tick, input logic e_ready);
        chk({tag, "_tick8"},  32'(tick8),      32'(e_tick));
        chk({tag, "_tick4"},  32'(tick4),      32'(e_tick));
        chk({tag, "_ready8"}, 32'(cfg_ready8), 32'(e_ready));
        chk({tag, "_ready4"}, 32'(cfg_ready4), 32'(e_ready));
    endtask

    // Offer is taken on the next edge; inputs are released afterwards.
    task automatic offer(input logic [1:0] m, input logic [RATE_W-1:0] r);
        cfg_valid = 1'b1;
        cfg_mode  = m;
        cfg_rate  = r;
        step();
        cfg_valid = 1'b0;
    endtask

    // Advance until a tick cycle; running out of budget is a failed check.
    task automatic wait_tick(input int budget);
        int n;
        n = 0;
        while (tick8 !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("wait_tick", 32'(tick8), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int hi;
        logic [31:0] exp_duty;

        // Reset state
        repeat (2) step();
        chk_led("reset", 8'h00, 4'h0);
        chk_hs("reset", 1'b0, 1'b1);
        #2 reset_reset_n = 1'b1;

        // COUNT at reset rate 3: first tick in clock 4 after release
        chk_hs("rel_c1", 1'b0, 1'b1);
        step();
        step();
        chk_hs("rel_c3", 1'b0, 1'b1);
        step();
        chk_hs("first_tick", 1'b1, 1'b1);
        chk_led("first_tick", 8'h00, 4'h0);
        for (int k = 1; k <= 258; k++) begin
            step();
            chk_led("count", k[7:0], k[3:0]);
            chk("count_tick_low", 32'(tick8), 32'd0);
            step();
            step();
            step();
            chk("count_tick", 32'(tick8), 32'd1);
        end

        // SCAN at rate 0; offer lands on a tick edge so apply is one period later
        offer(2'd1, 8'd0);
        chk_hs("scan_pend", 1'b0, 1'b0);
        chk_led("scan_pend", 8'h03, 4'h3);
        wait_tick(8);
        step();
        chk_hs("scan_apply", 1'b1, 1'b1);
        chk_led("scan_0", scan8_tbl[0], scan4_tbl[0]);
        for (int i = 1; i < 16; i++) begin
            step();
            chk_led("scan", scan8_tbl[i], scan4_tbl[i % 6]);
        end

        // Move to COUNT rate 9, then offer mid-period
        offer(2'd0, 8'd9);
        chk_hs("c9_pend", 1'b1, 1'b0);
        chk_led("c9_pend", 8'h04, 4'h4);
        step();
        chk_hs("c9_apply", 1'b0, 1'b1);
        chk_led("c9_apply", 8'h00, 4'h0);
        repeat (3) step();
        offer(2'd1, 8'd2);
        // Second offer while pending must be ignored
        cfg_valid = 1'b1;
        cfg_mode  = 2'd3;
        cfg_rate  = 8'd5;
        for (int j = 4; j < 9; j++) begin
            chk_hs("mid_wait", 1'b0, 1'b0);
            step();
        end
        chk_hs("mid_tick", 1'b1, 1'b0);
        chk_led("mid_tick", 8'h00, 4'h0);
        cfg_valid = 1'b0;
        step();
        chk_hs("mid_apply", 1'b0, 1'b1);
        chk_led("mid_apply", 8'h01, 4'h1);
        step();
        chk_hs("s2_c1", 1'b0, 1'b1);
        step();
        chk_hs("s2_tick", 1'b1, 1'b1);
        step();
        chk_led("s2_step1", 8'h02, 4'h2);
        wait_tick(8);
        step();
        chk_led("s2_step2", 8'h04, 4'h4);

        // Same mode reapplied: position returns to 0
        offer(2'd1, 8'd2);
        wait_tick(8);
        step();
        chk_led("reapply", 8'h01, 4'h1);
        chk_hs("reapply", 1'b0, 1'b1);

        // Asynchronous reset with a pending offer
        offer(2'd0, 8'd7);
        chk_hs("rst_pend", 1'b0, 1'b0);
        #2 reset_reset_n = 1'b0;
        #1;
        chk_led("async_rst", 8'h00, 4'h0);
        chk_hs("async_rst", 1'b0, 1'b1);
        step();
        step();
        #2 reset_reset_n = 1'b1;
        chk_hs("rst2_c1", 1'b0, 1'b1);
        step();
        step();
        chk_hs("rst2_c3", 1'b0, 1'b1);
        step();
        chk_hs("rst2_tick", 1'b1, 1'b1);
        step();
        chk_led("rst2_count", 8'h01, 4'h1);

`ifdef LED_PATTERN_BREATHE_EN
        // BREATHE at rate 63: duty 0 right after apply
        offer(2'd2, 8'd63);
        wait_tick(8);
        step();
        chk_hs("br_apply", 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk_led("br_duty0", 8'h00, 4'h0);
            step();
        end
        for (int t = 0; t < 5; t++) begin
            wait_tick(80);
            step();
        end
        step();
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            chk("br_all_bits", 32'((led4 == 4'hF) || (led4 == 4'h0)), 32'd1);
            if (led4 == 4'hF) hi++;
            step();
        end
        chk("br_duty5_high", 32'(hi), 32'd5);

        // Ramp at rate 0: 0..15, 14..0, 1
        offer(2'd2, 8'd0);
        wait_tick(80);
        step();
        for (int i = 0; i < 32; i++) begin
            exp_duty = (i <= 15) ? 32'(i) : ((i <= 30) ? 32'(30 - i) : 32'(i - 30));
            chk("br_ramp", 32'(u4.duty), exp_duty);
            step();
        end
`else
        // Mode 2 without the breathe engine: led freezes, tick continues
        exp_duty = 32'd0;
        hi = 0;
        offer(2'd2, 8'd1);
        wait_tick(8);
        chk_led("hold_pre", 8'h01, 4'h1);
        step();
        chk_hs("hold_apply", 1'b0, 1'b1);
        chk_led("hold_apply", 8'h01, 4'h1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk_hs("hold_tick", (i % 2) == 0, 1'b1);
            chk_led("hold", 8'h01, 4'h1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
